// File: rtl/axi_lite_master_bridge.sv
// Single-beat command-to-AXI4-Lite initiator bridge.
// One outstanding transaction, response returned on a one-cycle strobe.
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_cmd_stb,
    output logic                    o_cmd_rdy,
    input  logic                    i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    output logic                    o_rsp_stb,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    input  logic [1:0]              i_bresp,
    output logic                    o_bready,
    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,
    input  logic                    i_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    output logic                    o_rready
);

    localparam int              CW     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT_CYCLES);
    localparam bit              TO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_stb_q, rsp_stb_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_to_q, rsp_to_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic                    aw_ok;
    logic                    w_ok;
    logic                    timeout_hit;
    logic                    abort;

    assign o_cmd_rdy     = (state_q == IDLE) && i_axi_rst;
    assign o_awvalid     = awvalid_q;
    assign o_awaddr      = addr_q;
    assign o_wvalid      = wvalid_q;
    assign o_wdata       = wdata_q;
    assign o_wstrb       = wstrb_q;
    assign o_bready      = bready_q;
    assign o_arvalid     = arvalid_q;
    assign o_araddr      = addr_q;
    assign o_rready      = rready_q;
    assign o_rsp_stb     = rsp_stb_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_to_q;

    // A channel is finished once its valid has dropped or handshakes now.
    assign aw_ok       = !awvalid_q || i_awready;
    assign w_ok        = !wvalid_q || i_wready;
    assign timeout_hit = TO_EN && ((cnt_q + CW'(1)) == TO_LIM);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rsp_stb_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        rsp_to_d   = rsp_to_q;
        cnt_d      = cnt_q;
        abort      = 1'b0;

        if (TO_EN && state_q != IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (i_cmd_stb) begin
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_data;
                    wstrb_d = i_cmd_strb;
                    cnt_d   = '0;
                    if (i_cmd_wr) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && i_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && i_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok && w_ok) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else begin
                    abort = timeout_hit;
                end
            end
            WR_RESP: begin
                if (i_bvalid) begin
                    state_d    = IDLE;
                    bready_d   = 1'b0;
                    rsp_stb_d  = 1'b1;
                    rsp_data_d = '0;
                    rsp_resp_d = i_bresp;
                    rsp_to_d   = 1'b0;
                end else begin
                    abort = timeout_hit;
                end
            end
            RD_REQ: begin
                if (i_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    abort = timeout_hit;
                end
            end
            RD_RESP: begin
                if (i_rvalid) begin
                    state_d    = IDLE;
                    rready_d   = 1'b0;
                    rsp_stb_d  = 1'b1;
                    rsp_data_d = i_rdata;
                    rsp_resp_d = i_rresp;
                    rsp_to_d   = 1'b0;
                end else begin
                    abort = timeout_hit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Recovery abort: withdraw everything, report SLVERR with timeout flag.
        if (abort) begin
            state_d    = IDLE;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            rsp_stb_d  = 1'b1;
            rsp_data_d = '0;
            rsp_resp_d = 2'b10;
            rsp_to_d   = 1'b1;
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rsp_stb_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b00;
            rsp_to_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rsp_stb_q  <= rsp_stb_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
            rsp_to_q   <= rsp_to_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: timed slave model, response scoreboard,
// latency expected from channel delays.
module tb_axi_lite_master_bridge;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        to;
        logic        rdy;
        int          cyc;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        i_cmd_stb;
    logic        o_cmd_rdy;
    logic        i_cmd_wr;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic [3:0]  i_cmd_strb;
    logic        o_rsp_stb;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_timeout;
    logic        o_awvalid;
    logic [31:0] o_awaddr;
    logic        i_awready;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_wready;
    logic        i_bvalid;
    logic [1:0]  i_bresp;
    logic        o_bready;
    logic        o_arvalid;
    logic [31:0] o_araddr;
    logic        i_arready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        o_rready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int unstable = 0;
    logic [31:0] mon_awaddr, mon_wdata, mon_araddr;
    logic [3:0]  mon_wstrb;
    rsp_t rsp_q[$];

    axi_lite_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STROBE_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_axi_clk(clk),
        .i_axi_rst(rst_n),
        .i_cmd_stb(i_cmd_stb),
        .o_cmd_rdy(o_cmd_rdy),
        .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr),
        .i_cmd_data(i_cmd_data),
        .i_cmd_strb(i_cmd_strb),
        .o_rsp_stb(o_rsp_stb),
        .o_rsp_data(o_rsp_data),
        .o_rsp_resp(o_rsp_resp),
        .o_rsp_timeout(o_rsp_timeout),
        .o_awvalid(o_awvalid),
        .o_awaddr(o_awaddr),
        .i_awready(i_awready),
        .o_wvalid(o_wvalid),
        .o_wdata(o_wdata),
        .o_wstrb(o_wstrb),
        .i_wready(i_wready),
        .i_bvalid(i_bvalid),
        .i_bresp(i_bresp),
        .o_bready(o_bready),
        .o_arvalid(o_arvalid),
        .o_araddr(o_araddr),
        .i_arready(i_arready),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .i_rresp(i_rresp),
        .o_rready(o_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Observer: handshakes, responses and valid-hold, sampled mid-cycle.
    initial begin
        logic        pv_aw, pv_w, pv_ar;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        rsp_t        r;
        pv_aw = 0;
        pv_w = 0;
        pv_ar = 0;
        p_awaddr = 0;
        p_wdata = 0;
        p_araddr = 0;
        p_wstrb = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_cmd_stb && o_cmd_rdy) begin
                    acc_n++;
                    acc_cyc = cyc;
                end
                if (o_awvalid && i_awready) begin
                    aw_hs++;
                    mon_awaddr = o_awaddr;
                end
                if (o_wvalid && i_wready) begin
                    w_hs++;
                    mon_wdata = o_wdata;
                    mon_wstrb = o_wstrb;
                end
                if (o_arvalid && i_arready) begin
                    ar_hs++;
                    mon_araddr = o_araddr;
                end
                if (o_bready && i_bvalid) b_hs++;
                if (o_rready && i_rvalid) r_hs++;
                if (o_rsp_stb) begin
                    r.data = o_rsp_data;
                    r.resp = o_rsp_resp;
                    r.to = o_rsp_timeout;
                    r.rdy = o_cmd_rdy;
                    r.cyc = cyc;
                    rsp_q.push_back(r);
                end
                if (pv_aw && (!o_awvalid || o_awaddr !== p_awaddr)) unstable++;
                if (pv_w && (!o_wvalid || o_wdata !== p_wdata ||
                             o_wstrb !== p_wstrb)) unstable++;
                if (pv_ar && (!o_arvalid || o_araddr !== p_araddr)) unstable++;
                pv_aw = o_awvalid && !i_awready;
                pv_w = o_wvalid && !i_wready;
                pv_ar = o_arvalid && !i_arready;
                p_awaddr = o_awaddr;
                p_wdata = o_wdata;
                p_wstrb = o_wstrb;
                p_araddr = o_araddr;
            end else begin
                pv_aw = 0;
                pv_w = 0;
                pv_ar = 0;
            end
        end
    end

    task automatic do_txn(
        input  bit          wr,
        input  logic [31:0] addr,
        input  logic [31:0] data,
        input  logic [3:0]  strb,
        input  int          aw_d,
        input  int          w_d,
        input  int          b_d,
        input  int          ar_d,
        input  int          r_d,
        input  logic [1:0]  sresp,
        input  logic [31:0] sdata,
        input  bit          hang,
        output bit          got,
        output rsp_t        r,
        output int          lat
    );
        int aw0, w0, b0, ar0, r0;
        @(posedge clk);
        #1;
        aw0 = aw_hs;
        w0 = w_hs;
        b0 = b_hs;
        ar0 = ar_hs;
        r0 = r_hs;
        i_awready = (aw_d == 0);
        i_wready = (w_d == 0);
        i_arready = (ar_d == 0);
        i_bvalid = 0;
        i_rvalid = 0;
        i_cmd_stb = 1;
        i_cmd_wr = wr;
        i_cmd_addr = addr;
        i_cmd_data = data;
        i_cmd_strb = strb;
        @(posedge clk);
        #1;
        i_cmd_stb = 0;
        fork
            begin
                if (wr && aw_d > 0) begin
                    repeat (aw_d) @(posedge clk);
                    #1 i_awready = 1;
                end
            end
            begin
                if (wr && w_d > 0) begin
                    repeat (w_d) @(posedge clk);
                    #1 i_wready = 1;
                end
            end
            begin
                if (!wr && ar_d > 0) begin
                    repeat (ar_d) @(posedge clk);
                    #1 i_arready = 1;
                end
            end
            begin
                if (wr && !hang) begin
                    int n;
                    n = 0;
                    while (!(aw_hs > aw0 && w_hs > w0) && n < 50) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (b_d > 0) begin
                        repeat (b_d) @(posedge clk);
                        #1;
                    end
                    i_bvalid = 1;
                    i_bresp = sresp;
                    n = 0;
                    while (b_hs == b0 && n < 50) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    i_bvalid = 0;
                end
            end
            begin
                if (!wr && !hang) begin
                    int n;
                    n = 0;
                    while (ar_hs == ar0 && n < 50) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (r_d > 0) begin
                        repeat (r_d) @(posedge clk);
                        #1;
                    end
                    i_rvalid = 1;
                    i_rdata = sdata;
                    i_rresp = sresp;
                    n = 0;
                    while (r_hs == r0 && n < 50) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    i_rvalid = 0;
                end
            end
            begin
                int n;
                n = 0;
                while (rsp_q.size() == 0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        got = (rsp_q.size() != 0);
        lat = 0;
        r.data = 0;
        r.resp = 0;
        r.to = 0;
        r.rdy = 0;
        r.cyc = 0;
        if (got) begin
            r = rsp_q.pop_front();
            lat = r.cyc - acc_cyc;
        end
    endtask

    // Reference: expected response fields and accept-to-strobe latency.
    task automatic run_and_check(
        input string        tag,
        input bit           wr,
        input logic [31:0]  addr,
        input logic [31:0]  data,
        input logic [3:0]   strb,
        input int           aw_d,
        input int           w_d,
        input int           b_d,
        input int           ar_d,
        input int           r_d,
        input logic [1:0]   sresp,
        input logic [31:0]  sdata
    );
        bit   got;
        rsp_t r;
        int   lat, e_lat;
        int   d_aw, d_w, d_b, d_ar, d_r, u0;
        logic [31:0] e_data;
        d_aw = aw_hs;
        d_w = w_hs;
        d_b = b_hs;
        d_ar = ar_hs;
        d_r = r_hs;
        u0 = unstable;
        do_txn(wr, addr, data, strb, aw_d, w_d, b_d, ar_d, r_d, sresp,
               sdata, 0, got, r, lat);
        d_aw = aw_hs - d_aw;
        d_w = w_hs - d_w;
        d_b = b_hs - d_b;
        d_ar = ar_hs - d_ar;
        d_r = r_hs - d_r;
        e_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
        e_data = wr ? 32'h0 : sdata;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s no_response got 0 expected 1", tag);
        end else begin
            checks++;
            if (r.data !== e_data || r.resp !== sresp || r.to !== 1'b0) begin
                errors++;
                $display("FAIL %s rsp got %h/%b/%b expected %h/%b/0",
                         tag, r.data, r.resp, r.to, e_data, sresp);
            end
            checks++;
            if (lat !== e_lat) begin
                errors++;
                $display("FAIL %s latency got %0d expected %0d",
                         tag, lat, e_lat);
            end
            checks++;
            if (r.rdy !== 1'b1) begin
                errors++;
                $display("FAIL %s rdy_at_stb got %b expected 1", tag, r.rdy);
            end
        end
        checks++;
        if (wr ? (d_aw != 1 || d_w != 1 || d_b != 1 || d_ar != 0 || d_r != 0)
               : (d_aw != 0 || d_w != 0 || d_b != 0 || d_ar != 1 || d_r != 1)) begin
            errors++;
            $display("FAIL %s handshakes got aw%0d w%0d b%0d ar%0d r%0d",
                     tag, d_aw, d_w, d_b, d_ar, d_r);
        end
        checks++;
        if (wr ? (mon_awaddr !== addr || mon_wdata !== data || mon_wstrb !== strb)
               : (mon_araddr !== addr)) begin
            errors++;
            $display("FAIL %s beat got %h/%h/%h/%h expected addr %h data %h strb %h",
                     tag, mon_awaddr, mon_araddr, mon_wdata, mon_wstrb,
                     addr, data, strb);
        end
        checks++;
        if (unstable != u0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL %s hold/extra got unstable %0d extra %0d expected 0/0",
                     tag, unstable - u0, rsp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_stb} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids got %b expected 000000",
                     {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_stb});
        end
        checks++;
        if (o_rsp_data !== 32'h0 || o_rsp_resp !== 2'b00 || o_rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got %h/%b/%b expected 0/00/0",
                     o_rsp_data, o_rsp_resp, o_rsp_timeout);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (o_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy got %b expected 1", o_cmd_rdy);
        end
    endtask

    task automatic test_write_basic;
        run_and_check("write_basic", 1, 32'h0, 32'hA5A5_0001, 4'hF,
                      0, 0, 0, 0, 0, 2'b00, 32'h0);
    endtask

    task automatic test_read_basic;
        run_and_check("read_basic", 0, 32'h4, 32'h0, 4'h0,
                      0, 0, 0, 0, 0, 2'b00, 32'h1000_0000);
    endtask

    task automatic test_write_skew;
        run_and_check("skew_aw_first", 1, 32'h10, 32'h1111_2222, 4'h3,
                      0, 3, 0, 0, 0, 2'b00, 32'h0);
        run_and_check("skew_w_first", 1, 32'h14, 32'h3333_4444, 4'hC,
                      3, 0, 1, 0, 0, 2'b01, 32'h0);
        run_and_check("skew_together", 1, 32'h18, 32'h5555_6666, 4'h5,
                      2, 2, 2, 0, 0, 2'b00, 32'h0);
    endtask

    task automatic test_read_error;
        run_and_check("read_unmapped", 0, 32'hDEAD_0000, 32'h0, 4'h0,
                      0, 0, 0, 1, 2, 2'b10, 32'h0);
    endtask

    task automatic test_timeout;
        bit   got;
        rsp_t r;
        int   lat, b0;
        b0 = b_hs;
        do_txn(1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,
               1, got, r, lat);
        checks++;
        if (!got || r.data !== 32'h0 || r.resp !== 2'b10 || r.to !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp got %0d %h/%b/%b expected 1 0/10/1",
                     got, r.data, r.resp, r.to);
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL timeout_latency got %0d expected 17", lat);
        end
        @(negedge clk);
        checks++;
        if (o_cmd_rdy !== 1'b1 ||
            {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 5'b0) begin
            errors++;
            $display("FAIL timeout_idle got rdy %b valids %b expected 1/00000",
                     o_cmd_rdy, {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
        end
        checks++;
        if (b_hs != b0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_extra got b %0d rsp %0d expected 0/0",
                     b_hs - b0, rsp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge clk);
        #1;
        i_arready = 1;
        i_rvalid = 0;
        i_cmd_stb = 1;
        i_cmd_wr = 0;
        i_cmd_addr = 32'h8;
        @(posedge clk);
        #1;
        i_cmd_stb = 0;
        n = 0;
        while (!o_rready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (o_rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_rd_resp got %b expected 1", o_rready);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (o_rready !== 1'b0 || o_rsp_stb !== 1'b0 || o_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got rready %b stb %b arvalid %b expected 0",
                     o_rready, o_rsp_stb, o_arvalid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (o_cmd_rdy !== 1'b1 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_release got rdy %b rsp %0d expected 1/0",
                     o_cmd_rdy, rsp_q.size());
        end
        run_and_check("read_after_reset", 0, 32'h8, 32'h0, 4'h0,
                      0, 0, 0, 0, 0, 2'b00, 32'h0BAD_BEEF);
    endtask

    task automatic test_back_to_back;
        int          a0, r0;
        logic [31:0] x;
        rsp_t        rs[$];
        x = $urandom;
        @(posedge clk);
        #1;
        a0 = acc_n;
        r0 = r_hs;
        i_arready = 1;
        i_rvalid = 1;
        i_rresp = 2'b00;
        i_rdata = x;
        i_cmd_stb = 1;
        i_cmd_wr = 0;
        i_cmd_addr = 32'h40;
        repeat (12) @(posedge clk);
        #1;
        i_cmd_stb = 0;
        repeat (4) @(negedge clk);
        i_rvalid = 0;
        while (rsp_q.size() != 0) rs.push_back(rsp_q.pop_front());
        checks++;
        if (acc_n - a0 != 4 || r_hs - r0 != 4 || rs.size() != 4) begin
            errors++;
            $display("FAIL b2b_counts got acc %0d r %0d rsp %0d expected 4/4/4",
                     acc_n - a0, r_hs - r0, rs.size());
        end
        for (int i = 0; i < rs.size(); i++) begin
            checks++;
            if (rs[i].data !== x || rs[i].resp !== 2'b00 || rs[i].rdy !== 1'b1 ||
                (i > 0 && rs[i].cyc - rs[i-1].cyc != 3)) begin
                errors++;
                $display("FAIL b2b_rsp%0d got %h/%b/%b expected %h/00/1 spacing 3",
                         i, rs[i].data, rs[i].resp, rs[i].rdy, x);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            bit          wr;
            logic [31:0] addr, data, sdata;
            logic [3:0]  strb;
            logic [1:0]  sresp;
            wr = $urandom_range(0, 1);
            addr = {$urandom} & 32'hFFFF_FFFC;
            data = $urandom;
            sdata = $urandom;
            strb = 4'($urandom_range(0, 15));
            sresp = 2'($urandom_range(0, 3));
            run_and_check($sformatf("random%0d", i), wr, addr, data, strb,
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), sresp, sdata);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        i_cmd_stb = 0;
        i_cmd_wr = 0;
        i_cmd_addr = 0;
        i_cmd_data = 0;
        i_cmd_strb = 0;
        i_awready = 0;
        i_wready = 0;
        i_bvalid = 0;
        i_bresp = 0;
        i_arready = 0;
        i_rvalid = 0;
        i_rdata = 0;
        i_rresp = 0;
        rst_n = 0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_skew();
        test_read_error();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
